i2c_master_controller: RTL
==========================

// Module: i2c_master_controller
// PURPOSE
//  Byte-level I2C master serving the sensor interfaces (humidity, temperature) on the shared bus.
//  Accepts a start_read request with 7-bit address and R/W flag; runs START/addr/data/STOP on
//  open-drain SCL/SDA. Returns read bytes one at a time with a transaction_done pulse each.
//  Sits between sensor interface FSMs and the chip-level I2C pads.
// PARAMETERS
//  CLK_DIV     250  clk cycles per quarter SCL period (100 MHz -> 100 kHz SCL)
//  READ_BYTES  2    bytes returned per read request (MSB first on the bus, 1..4)
// PORTS
//  clk               in   1  system clock
//  rst_n             in   1  asynchronous active-low reset
//  start_read        in   1  request; accepted only in IDLE (level-sampled)
//  slave_addr        in   7  target address, captured on accept
//  read_write_n      in   1  1 = read READ_BYTES bytes, 0 = write one byte; captured on accept
//  write_data        in   8  write payload, captured on accept
//  i2c_read_data     out  8  last received byte; valid in the transaction_done cycle, held after
//  transaction_done  out  1  1-cycle pulse per completed data byte
//  ack_error         out  1  1-cycle pulse on slave NACK of address or write byte
//  busy              out  1  high from accept until bus-free time after STOP expires
//  scl_oe            out  1  1 = pull SCL low, 0 = release
//  sda_oe            out  1  1 = pull SDA low, 0 = release
//  sda_i             in   1  SDA pad level (pre-synchronised by 2 flops internally)
//  scl_i             in   1  SCL pad level (used only with I2C_CLK_STRETCH_EN)
// BEHAVIOUR
//  Reset (async, immediate): scl_oe=0, sda_oe=0, busy=0, transaction_done=0, ack_error=0,
//   i2c_read_data=8'h00, state=IDLE, divider=0, bit/byte counters=0. Mid-transfer reset
//   releases both lines at once; no STOP is generated.
//  Tick: divider counts 0..CLK_DIV-1, tick on wrap; divider runs only when state!=IDLE.
//  Bit = 4 ticks: q0 drive SDA (SCL low), q1 release SCL, q2 sample SDA, q3 pull SCL low.
//  FSM: IDLE -> START -> ADDR(8 bits {addr,rw}) -> ADDR_ACK -> WR_BYTE -> WR_ACK -> STOP
//   or ADDR_ACK -> RD_BYTE -> M_ACK -> (RD_BYTE | STOP) -> BUS_FREE -> IDLE.
//  IDLE: start_read=1 -> capture inputs, busy=1, START next cycle. Held-high start_read while
//   busy is ignored; still high on return to IDLE starts a new transfer.
//  START: SDA low while SCL high (2 ticks), then SCL low.
//  ADDR_ACK/WR_ACK: SDA released; sampled 1 -> ack_error pulse (no transaction_done), go STOP.
//  WR_ACK sampled 0 -> transaction_done pulse (i2c_read_data unchanged), go STOP.
//  RD_BYTE: shift in MSB first on q2. M_ACK: master drives ACK (0) for bytes 1..READ_BYTES-1,
//   NACK (1) on last byte. transaction_done pulses in the cycle after M_ACK q3 with
//   i2c_read_data = received byte; at most one pulse per byte, >= 4*CLK_DIV cycles apart.
//  STOP: SDA low, SCL released, then SDA released while SCL high.
//  BUS_FREE: 4 ticks idle (tBUF), busy still 1; busy drops on entry to IDLE.
//  ack_error and transaction_done never assert in the same cycle.
//  Read latency (no stretch): first transaction_done at 4*CLK_DIV*(2+9+9) cycles after accept,
//   within +/-2 clk cycles.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined: in q1 the FSM holds (divider frozen) until synchronised scl_i=1,
//   i.e. slave clock stretching honoured; no timeout.
//  Not defined: scl_i ignored; SCL timing purely from divider (slave must not stretch).
// TESTING (sim CLK_DIV=4, READ_BYTES=2, slave BFM on open-drain bus)
//  Read 0x40, slave ACKs, sends 8'hA5, 8'h3C -> two transaction_done pulses, data A5 then 3C;
//   bus sees addr byte 8'h81, master ACK then NACK, STOP; busy low after tBUF.
//  Read to absent address (BFM NACKs) -> one ack_error pulse, no transaction_done, STOP, busy=0.
//  Write 0x40 data 8'h5A, slave ACKs -> byte 8'h80 then 8'h5A on bus, one transaction_done.
//  start_read held high 2 cycles -> exactly one transfer; held high through end -> second starts.
//  rst_n low mid-RD_BYTE -> scl_oe=sda_oe=0 same cycle, busy=0; next start_read runs cleanly.
//  With I2C_CLK_STRETCH_EN, BFM holds SCL low 50 cycles on ACK -> timing shifts by 50, data OK.

Source files
------------

// File: rtl/i2c_master_controller.sv
// Byte-level open-drain I2C master: START, address, one write byte or READ_BYTES read bytes, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching while SCL is released.
module i2c_master_controller #(
    parameter int CLK_DIV    = 250,
    parameter int READ_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_read,
    input  logic [6:0] slave_addr,
    input  logic       read_write_n,
    input  logic [7:0] write_data,
    output logic [7:0] i2c_read_data,
    output logic       transaction_done,
    output logic       ack_error,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic       scl_i
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0] LAST_BYTE = 2'(READ_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_ADDR     = 4'd2,
        S_ADDR_ACK = 4'd3,
        S_WR_BYTE  = 4'd4,
        S_WR_ACK   = 4'd5,
        S_RD_BYTE  = 4'd6,
        S_M_ACK    = 4'd7,
        S_STOP     = 4'd8,
        S_BUS_FREE = 4'd9
    } state_t;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       q_r;
    logic [2:0]       bit_r, bit_s;
    logic [1:0]       byte_r, byte_s;
    logic [7:0]       addr_byte_r, wdata_r, rx_r, rd_data_r, tx_byte_s;
    logic             ack_r;
    logic             done_r, done_s, err_r, err_s, busy_r, busy_s;
    logic             scl_oe_r, scl_s, sda_oe_r, sda_s;
    logic             sda_meta_r, sda_sync_r;
    logic             accept_s, hold_s, tick_s, bit_end_s, sample_s, bit_scl_s;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_meta_r, scl_sync_r;
    logic stretch_state_s;

    // Two-flop synchroniser for the SCL pad, used to detect slave stretching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
        end
    end

    assign stretch_state_s = (state_r == S_ADDR) || (state_r == S_ADDR_ACK) ||
                             (state_r == S_WR_BYTE) || (state_r == S_WR_ACK) ||
                             (state_r == S_RD_BYTE) || (state_r == S_M_ACK) ||
                             (state_r == S_STOP);
    assign hold_s = stretch_state_s && (q_r == 2'd1) && !scl_sync_r;
`else
    logic unused_scl_s;
    assign unused_scl_s = scl_i;
    assign hold_s       = 1'b0;
`endif

    assign tick_s    = (state_r != S_IDLE) && !hold_s && (div_r == DIV_LAST);
    assign bit_end_s = tick_s && (q_r == 2'd3);
    assign sample_s  = tick_s && (q_r == 2'd2);
    assign bit_scl_s = (q_r == 2'd0) || (q_r == 2'd3);
    assign tx_byte_s = (state_r == S_ADDR) ? addr_byte_r : wdata_r;

    // Two-flop synchroniser for the SDA pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Quarter-period divider and quarter counter; parked at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DIV_W{1'b0}};
            q_r   <= 2'd0;
        end else if (state_r == S_IDLE) begin
            div_r <= {DIV_W{1'b0}};
            q_r   <= 2'd0;
        end else if (hold_s) begin
            div_r <= div_r;
            q_r   <= q_r;
        end else if (div_r == DIV_LAST) begin
            div_r <= {DIV_W{1'b0}};
            q_r   <= q_r + 2'd1;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // FSM state, counters and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            bit_r    <= 3'd0;
            byte_r   <= 2'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            scl_oe_r <= 1'b0;
            sda_oe_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            bit_r    <= bit_s;
            byte_r   <= byte_s;
            done_r   <= done_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
            scl_oe_r <= scl_s;
            sda_oe_r <= sda_s;
        end
    end

    // Next-state and line-drive decode; transitions happen on the q3 tick of each bit.
    always_comb begin
        state_s  = state_r;
        bit_s    = bit_r;
        byte_s   = byte_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        busy_s   = busy_r;
        scl_s    = 1'b0;
        sda_s    = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_s = 1'b0;
                if (start_read) begin
                    accept_s = 1'b1;
                    busy_s   = 1'b1;
                    bit_s    = 3'd0;
                    byte_s   = 2'd0;
                    state_s  = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                // First bit-time: bus idle then SDA falls with SCL high; second: SCL low.
                scl_s = bit_r[0];
                sda_s = bit_r[0] | q_r[1];
                if (bit_end_s) begin
                    if (bit_r[0]) begin
                        bit_s   = 3'd0;
                        state_s = S_ADDR;
                    end else begin
                        bit_s = 3'd1;
                    end
                end else begin
                    bit_s = bit_r;
                end
            end
            S_ADDR, S_WR_BYTE: begin
                scl_s = bit_scl_s;
                sda_s = ~tx_byte_s[3'd7 - bit_r];
                if (bit_end_s) begin
                    bit_s = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s = (state_r == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    bit_s = bit_r;
                end
            end
            S_ADDR_ACK: begin
                scl_s = bit_scl_s;
                if (bit_end_s) begin
                    if (ack_r) begin
                        err_s   = 1'b1;
                        state_s = S_STOP;
                    end else if (addr_byte_r[0]) begin
                        state_s = S_RD_BYTE;
                    end else begin
                        state_s = S_WR_BYTE;
                    end
                end else begin
                    state_s = S_ADDR_ACK;
                end
            end
            S_WR_ACK: begin
                scl_s = bit_scl_s;
                if (bit_end_s) begin
                    err_s   = ack_r;
                    done_s  = ~ack_r;
                    state_s = S_STOP;
                end else begin
                    state_s = S_WR_ACK;
                end
            end
            S_RD_BYTE: begin
                scl_s = bit_scl_s;
                if (bit_end_s) begin
                    bit_s   = bit_r + 3'd1;
                    state_s = (bit_r == 3'd7) ? S_M_ACK : S_RD_BYTE;
                end else begin
                    bit_s = bit_r;
                end
            end
            S_M_ACK: begin
                scl_s = bit_scl_s;
                sda_s = (byte_r != LAST_BYTE);
                if (bit_end_s) begin
                    done_s = 1'b1;
                    if (byte_r == LAST_BYTE) begin
                        byte_s  = 2'd0;
                        state_s = S_STOP;
                    end else begin
                        byte_s  = byte_r + 2'd1;
                        state_s = S_RD_BYTE;
                    end
                end else begin
                    byte_s = byte_r;
                end
            end
            S_STOP: begin
                scl_s = (q_r == 2'd0);
                sda_s = (q_r != 2'd3);
                if (bit_end_s) begin
                    state_s = S_BUS_FREE;
                end else begin
                    state_s = S_STOP;
                end
            end
            S_BUS_FREE: begin
                if (bit_end_s) begin
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BUS_FREE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    // Request capture, ACK/data sampling on q2, and read-data hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_byte_r <= 8'h00;
            wdata_r     <= 8'h00;
            rx_r        <= 8'h00;
            ack_r       <= 1'b1;
            rd_data_r   <= 8'h00;
        end else begin
            if (accept_s) begin
                addr_byte_r <= {slave_addr, read_write_n};
                wdata_r     <= write_data;
            end
            if (sample_s) begin
                ack_r <= sda_sync_r;
                if (state_r == S_RD_BYTE) begin
                    rx_r <= {rx_r[6:0], sda_sync_r};
                end
            end
            if (done_s && (state_r == S_M_ACK)) begin
                rd_data_r <= rx_r;
            end
        end
    end

    assign i2c_read_data    = rd_data_r;
    assign transaction_done = done_r;
    assign ack_error        = err_r;
    assign busy             = busy_r;
    assign scl_oe           = scl_oe_r;
    assign sda_oe           = sda_oe_r;

endmodule
